sumador_pipe: RTL

//  Parametrised, pipelined signed/unsigned add/subtract unit with valid/ack flow control on both sides.

---
 rtl/sumador_pipe_if.sv | 43 ++++
 rtl/sumador_pipe.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sumador_pipe_if.sv
// ----------------------------------------------------------------------------
// sumador_pipe_if
//   Stream bundle between a producer/consumer pair and the sumador_pipe
//   add/subtract pipeline.
//   Producer side : a, b, op, carry_in, input_valid  -> unit ; input_ack <- unit
//   Consumer side : sum, overflow, carry_out, output_valid <- unit ;
//                   output_ack -> unit
//   Status        : level (occupied stages) <- unit
//   Modports:
//     master - the environment (drives operands and output_ack)
//     slave  - the arithmetic unit
// ----------------------------------------------------------------------------
interface sumador_pipe_if #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
);
    localparam int LVLW = $clog2(STAGES + 1);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
    logic             carry_in;
    logic             input_valid;
    logic             input_ack;

    logic [WIDTH-1:0] sum;
    logic             overflow;
    logic             carry_out;
    logic             output_valid;
    logic             output_ack;

    logic [LVLW-1:0]  level;

    modport master (
        output a, b, op, carry_in, input_valid, output_ack,
        input  input_ack, sum, overflow, carry_out, output_valid, level
    );

    modport slave (
        input  a, b, op, carry_in, input_valid, output_ack,
        output input_ack, sum, overflow, carry_out, output_valid, level
    );
endinterface

// File: rtl/sumador_pipe.sv
// ----------------------------------------------------------------------------
// sumador_pipe
//   Pipelined signed/unsigned add/subtract unit with valid/ack flow control
//   on both sides. The result is computed combinationally from the operands
//   and captured into stage 0 on an accepted input; STAGES elastic register
//   stages carry it to the output. The ready chain lets a full pipe accept
//   and emit in the same cycle, so there are no bubbles.
//
//   Ports:
//     clk  - clock, all state on the rising edge
//     rst  - asynchronous, active-low reset (rst==0 clears the pipe)
//     bus  - sumador_pipe_if.slave: operands/op/carry_in/input_valid in,
//            input_ack out, sum/overflow/carry_out/output_valid out,
//            output_ack in, level out (occupied stage count)
//
//   Parameters: WIDTH (>=2) operand width, STAGES (>=1) latency in cycles.
//
//   Build option:
//     SUMADOR_SAT_EN - when defined, a signed overflow replaces the stage-0
//                      sum with the signed saturation value; overflow and
//                      carry_out are still reported. Undefined: sum wraps.
// ----------------------------------------------------------------------------
module sumador_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    sumador_pipe_if.slave bus
);
    localparam int LVLW = $clog2(STAGES + 1);

    // ------------------------------------------------------------------
    // Arithmetic: subtraction is a + ~b + ~borrow_in, so a single adder
    // serves both ops; carry_out is inverted back into a borrow for sub.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] bx;
    logic             cx;
    logic [WIDTH:0]   raw;
    logic [WIDTH-1:0] sum_in;
    logic             ovf_in;
    logic             cout_in;

    always_comb begin
        bx      = bus.op ? ~bus.b : bus.b;
        cx      = bus.op ? ~bus.carry_in : bus.carry_in;
        raw     = {1'b0, bus.a} + {1'b0, bx} + {{WIDTH{1'b0}}, cx};
        // Same-sign operands producing a result of the other sign.
        ovf_in  = (bus.a[WIDTH-1] == bx[WIDTH-1]) && (raw[WIDTH-1] != bus.a[WIDTH-1]);
        cout_in = bus.op ? ~raw[WIDTH] : raw[WIDTH];
`ifdef SUMADOR_SAT_EN
        // On overflow the true result lies beyond the range on a's side.
        if (ovf_in) begin
            sum_in = bus.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            sum_in = raw[WIDTH-1:0];
        end
`else
        sum_in = raw[WIDTH-1:0];
`endif
    end

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic [STAGES-1:0]            v_q, v_d;
    logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
    logic [STAGES-1:0]            ovf_q, ovf_d;
    logic [STAGES-1:0]            cout_q, cout_d;
    logic [LVLW-1:0]              level_q, level_d;

    // What each stage would load: the inputs for stage 0, the previous
    // stage otherwise.
    logic [STAGES-1:0]            up_v;
    logic [STAGES-1:0][WIDTH-1:0] up_sum;
    logic [STAGES-1:0]            up_ovf;
    logic [STAGES-1:0]            up_cout;

    logic [STAGES-1:0]            adv;
    logic                         in_hs;
    logic                         out_hs;

    // Ready chain: a stage may load when it is empty or when the stage
    // after it is moving on this cycle.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = ~v_q[STAGES-1] | bus.output_ack;
        for (int i = STAGES - 2; i >= 0; i--) begin
            adv[i] = ~v_q[i] | adv[i+1];
        end
    end

    always_comb begin
        up_v       = '0;
        up_sum     = '0;
        up_ovf     = '0;
        up_cout    = '0;
        up_v[0]    = bus.input_valid;
        up_sum[0]  = sum_in;
        up_ovf[0]  = ovf_in;
        up_cout[0] = cout_in;
        for (int i = 1; i < STAGES; i++) begin
            up_v[i]    = v_q[i-1];
            up_sum[i]  = sum_q[i-1];
            up_ovf[i]  = ovf_q[i-1];
            up_cout[i] = cout_q[i-1];
        end
    end

    always_comb begin
        v_d    = v_q;
        sum_d  = sum_q;
        ovf_d  = ovf_q;
        cout_d = cout_q;
        for (int i = 0; i < STAGES; i++) begin
            if (adv[i]) begin
                v_d[i] = up_v[i];
                // Payload only moves with valid data, so an emptied output
                // stage keeps presenting its last result.
                if (up_v[i]) begin
                    sum_d[i]  = up_sum[i];
                    ovf_d[i]  = up_ovf[i];
                    cout_d[i] = up_cout[i];
                end
            end
        end
    end

    // Occupancy counter tracks the handshakes directly.
    always_comb begin
        in_hs  = bus.input_valid & adv[0];
        out_hs = v_q[STAGES-1] & bus.output_ack;
        case ({in_hs, out_hs})
            2'b10:   level_d = level_q + LVLW'(1);
            2'b01:   level_d = level_q - LVLW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q     <= '0;
            sum_q   <= '0;
            ovf_q   <= '0;
            cout_q  <= '0;
            level_q <= '0;
        end else begin
            v_q     <= v_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            cout_q  <= cout_d;
            level_q <= level_d;
        end
    end

    assign bus.input_ack    = adv[0];
    assign bus.sum          = sum_q[STAGES-1];
    assign bus.overflow     = ovf_q[STAGES-1];
    assign bus.carry_out    = cout_q[STAGES-1];
    assign bus.output_valid = v_q[STAGES-1];
    assign bus.level        = level_q;
endmodule
